// File: rtl/sha256_msg_fetch.sv
// SHA-256 message fetch and padding front-end: reads message words from SRAM and streams padded W words.
// Optional build macro SHA_FETCH_BSWAP_EN byte-reverses each memory word before masking.
module sha256_msg_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] size,
  output logic        busy,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic        w_first,
  output logic        w_last,
  output logic        w_final
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, DONE} state_t;
  state_t state, state_nx;

  logic [15:0] base;
  logic [31:0] len, idx, n_words, m_words;
  logic [31:0] idx_inc, req_n, req_m, mem_word;
  logic [2:0]  tag;
  logic        last_word;
  logic        unused_addr_hi;

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign unused_addr_hi = ^message_addr[31:16];
  assign {w_first, w_last, w_final} = tag;

  // Block count leaves room for the 0x80 marker plus the 8-byte length field.
  assign req_n     = (((size + 32'd8) >> 6) + 32'd1) << 4;
  assign req_m     = (size >> 2) + {31'd0, |size[1:0]};
  assign idx_inc   = idx + 32'd1;
  assign last_word = (idx == n_words - 32'd1);

`ifdef SHA_FETCH_BSWAP_EN
  assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                     mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign mem_word = mem_read_data;
`endif

  function automatic logic [31:0] pad_word(input logic [31:0] i, input logic [31:0] sz,
                                           input logic [31:0] n);
    logic [31:0] r;
    r = 32'd0;
    if ({i, 2'b00} == {2'b00, sz}) r = 32'h8000_0000;
    else if (i == n - 32'd2)       r = {29'd0, sz[31:29]};
    else if (i == n - 32'd1)       r = {sz[28:0], 3'b000};
    return r;
  endfunction

  // Only called for words that overlap the message, so the tail is either full or partial.
  function automatic logic [31:0] msg_word(input logic [31:0] d, input logic [31:0] i,
                                           input logic [31:0] sz);
    logic [33:0] byte_end;
    logic [31:0] r;
    byte_end = {i, 2'b00} + 34'd4;
    r = d;
    if (byte_end > {2'b00, sz}) begin
      case (sz[1:0])
        2'd1:    r = {d[31:24], 24'h80_0000};
        2'd2:    r = {d[31:16], 16'h8000};
        2'd3:    r = {d[31:8], 8'h80};
        default: r = d;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] flags(input logic [31:0] i, input logic [31:0] n);
    return {i[3:0] == 4'd0, i[3:0] == 4'hf, i >= n - 32'd16};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    w_valid  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (req_m != 32'd0) ? FETCH : OUT;
      FETCH: begin
        busy     = 1'b1;
        state_nx = WAIT;
      end
      WAIT:  begin
        busy     = 1'b1;
        state_nx = OUT;
      end
      OUT:   begin
        busy    = 1'b1;
        w_valid = 1'b1;
        if (w_ready) begin
          if (last_word)              state_nx = DONE;
          else if (idx_inc < m_words) state_nx = FETCH;
          else                        state_nx = OUT;
        end
      end
      DONE:  begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base     <= '0;
      len      <= '0;
      idx      <= '0;
      n_words  <= '0;
      m_words  <= '0;
      mem_addr <= '0;
      w_data   <= '0;
      tag      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base     <= message_addr[15:0];
          len      <= size;
          n_words  <= req_n;
          m_words  <= req_m;
          idx      <= '0;
          mem_addr <= message_addr[15:0];
          if (req_m == 32'd0) begin
            w_data <= pad_word(32'd0, size, req_n);
            tag    <= flags(32'd0, req_n);
          end
        end
        WAIT: begin
          w_data <= msg_word(mem_word, idx, len);
          tag    <= flags(idx, n_words);
        end
        // Pad words reload in place so they stream one per cycle.
        OUT: if (w_ready) begin
          idx <= idx_inc;
          if (!last_word) begin
            if (idx_inc < m_words) mem_addr <= base + idx_inc[15:0];
            else begin
              w_data <= pad_word(idx_inc, len, n_words);
              tag    <= flags(idx_inc, n_words);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_fetch.sv
// Bench for sha256_msg_fetch: byte-level padding model, per-cycle compare process, directed vectors.
module tb_sha256_msg_fetch;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] message_addr = '0, size = '0;
  logic        busy, done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data = '0;
  logic        w_valid, w_ready = 1'b1;
  logic [31:0] w_data;
  logic        w_first, w_last, w_final;

  sha256_msg_fetch dut (
    .clk(clk), .reset(reset), .start(start), .message_addr(message_addr), .size(size),
    .busy(busy), .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_read_data(mem_read_data), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_first(w_first), .w_last(w_last), .w_final(w_final)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0, total_cnt = 0;
  logic [15:0] cur_base = '0;
  logic [31:0] cur_seed = '0;
  logic [31:0] exp_w [0:255];
  logic [31:0] got   [0:255];
  int          exp_n = 0, exp_idx = 0, fetch_cycles = 0, done_cnt = 0, stall_cycles = 0;
  bit          chk_en = 1'b0, stall_en = 1'b0, held = 1'b0;
  logic [31:0] hd;
  logic [2:0]  hf;
  logic [15:0] ha;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Memory image: word k after the base is the seed rotated left by k.
  function automatic logic [31:0] memword(input logic [15:0] a);
    logic [15:0] k;
    logic [5:0]  r;
    k = a - cur_base;
    r = {1'b0, k[4:0]};
    return (cur_seed << r) | (cur_seed >> (6'd32 - r));
  endfunction

  function automatic logic [7:0] msg_byte(input int j);
    logic [31:0] w;
    w = memword(cur_base + 16'(j / 4));
`ifdef SHA_FETCH_BSWAP_EN
    return w[8 * (j % 4) +: 8];
`else
    return w[24 - 8 * (j % 4) +: 8];
`endif
  endfunction

  // Padded message as a byte stream, then packed big-endian into words.
  task automatic build_model(input int s);
    logic [7:0]  bytes [0:1023];
    logic [63:0] bits;
    int          total;
    total = ((s + 9 + 63) / 64) * 64;
    bits  = 64'(s) << 3;
    for (int j = 0; j < total; j++)
      bytes[j] = (j < s) ? msg_byte(j) : ((j == s) ? 8'h80 : 8'h00);
    for (int k = 0; k < 8; k++) bytes[total - 1 - k] = bits[8 * k +: 8];
    exp_n = total / 4;
    for (int i = 0; i < exp_n; i++)
      exp_w[i] = {bytes[4 * i], bytes[4 * i + 1], bytes[4 * i + 2], bytes[4 * i + 3]};
  endtask

  // Registered-read SRAM responder.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge clk);
      a = mem_addr;
      @(posedge clk);
      #1 mem_read_data = memword(a);
    end
  end

  // Consumer: holds ready low for five valid cycles on word 3 when asked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && w_valid && exp_idx == 3 && stall_cycles < 5) begin
        w_ready = 1'b0;
        stall_cycles++;
      end else w_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (busy && !w_valid) fetch_cycles++;
      if (done) begin
        done_cnt++;
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_word_count", 32'(exp_idx), 32'(exp_n));
      end
      if (w_valid) begin
        if (held) begin
          check("stall_data", w_data, hd);
          check("stall_flags", 32'({w_first, w_last, w_final}), 32'(hf));
          check("stall_addr", 32'(mem_addr), 32'(ha));
        end
        if (w_ready) begin
          if (exp_idx < exp_n) begin
            check("word", w_data, exp_w[exp_idx]);
            check("flags", 32'({w_first, w_last, w_final}),
                  32'({exp_idx % 16 == 0, exp_idx % 16 == 15, exp_idx >= exp_n - 16}));
            got[exp_idx] = w_data;
          end else check("extra_word", 32'(exp_idx), 32'(exp_n));
          exp_idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = w_data;
          hf   = {w_first, w_last, w_final};
          ha   = mem_addr;
        end
      end else held = 1'b0;
    end
  end

  task automatic run_msg(input logic [15:0] b, input logic [31:0] sd, input int s,
                         input bit stall, input int abort_at);
    int m;
    m = (s + 3) / 4;
    cur_base = b;
    cur_seed = sd;
    build_model(s);
    exp_idx = 0; fetch_cycles = 0; done_cnt = 0; held = 1'b0; stall_cycles = 0;
    stall_en = stall;
    for (int k = 0; k < 256; k++) got[k] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk_en = 1'b1; start = 1'b1; message_addr = {16'h5A5A, b}; size = 32'(s);
    @(posedge clk); #1;
    start = 1'b0; message_addr = 32'h0000_1234; size = 32'd999;
    check("busy_rise", 32'(busy), 32'd1);
    check("first_valid", 32'(w_valid), 32'(m == 0));
    if (m > 0) check("first_addr", 32'(mem_addr), 32'(b));
    @(posedge clk); #1;
    start = 1'b1; size = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1 chk_en = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_valid", 32'(w_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_data", w_data, 32'd0);
      return;
    end
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(posedge clk);
    if (done_cnt == 0) check("timeout_done", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("words_out", 32'(exp_idx), 32'(exp_n));
    check("fetch_cycles", 32'(fetch_cycles), 32'(2 * m));
    check("idle_busy", 32'(busy), 32'd0);
    chk_en = 1'b0;
    stall_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(w_valid), 32'd0);
    check("rst_data", w_data, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_flags", 32'({w_first, w_last, w_final}), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    reset = 1'b0;

    run_msg(16'h0100, 32'h0123_4567, 120, 1'b1, 0);
`ifndef SHA_FETCH_BSWAP_EN
    check("s120_w0", got[0], 32'h0123_4567);
    check("s120_w1", got[1], 32'h0246_8ACE);
`endif
    check("s120_w30", got[30], 32'h8000_0000);
    check("s120_w46", got[46], 32'h0000_0000);
    check("s120_w47", got[47], 32'h0000_03C0);
    check("s120_n", 32'(exp_idx), 32'd48);

    run_msg(16'h0200, 32'h0123_4567, 0, 1'b1, 0);
    check("s0_w0", got[0], 32'h8000_0000);
    check("s0_w15", got[15], 32'h0000_0000);
    check("s0_n", 32'(exp_idx), 32'd16);

    run_msg(16'hFFFF, 32'h0123_4567, 5, 1'b0, 0);
`ifndef SHA_FETCH_BSWAP_EN
    check("s5_w1", got[1], 32'h0280_0000);
`endif
    check("s5_w15", got[15], 32'h0000_0028);

    run_msg(16'h0300, 32'h89AB_CDEF, 56, 1'b0, 0);
    check("s56_w14", got[14], 32'h8000_0000);
    check("s56_w31", got[31], 32'h0000_01C0);
    check("s56_n", 32'(exp_idx), 32'd32);

    run_msg(16'h0400, 32'hF00D_0001, 55, 1'b1, 0);
    check("s55_w15", got[15], 32'h0000_01B8);

    run_msg(16'h0100, 32'h0123_4567, 120, 1'b0, 20);
    run_msg(16'h0100, 32'h0123_4567, 120, 1'b0, 0);
    check("rerun_w47", got[47], 32'h0000_03C0);

    run_msg(16'h0500, 32'h6745_2301, 8, 1'b0, 0);
`ifdef SHA_FETCH_BSWAP_EN
    check("swap_w0", got[0], 32'h0123_4567);
`else
    check("raw_w0", got[0], 32'h6745_2301);
`endif
    check("s8_w2", got[2], 32'h8000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
